// File: rtl/inc_4_arbiter_pkg.sv
// Shared state encodings and operand width for the inc_4 arbiter.
package inc_4_arbiter_pkg;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/inc_4.sv
// Registered 4-bit incrementer (modulo 16, no carry out); one cycle latency, no reset.
module inc_4
  import inc_4_arbiter_pkg::*;
(
  input  logic            i_Clk,
  input  logic [OP_W-1:0] i_Operand,
  output logic [OP_W-1:0] o_Result
);

  always_ff @(posedge i_Clk) begin
    o_Result <= i_Operand + OP_W'(1);
  end

endmodule

// File: rtl/inc_4_arbiter.sv
// Round-robin arbiter sharing one inc_4 among NUM_REQ requesters.
// Accept -> issue -> capture: result and valid pulse two edges after the grant edge.
module inc_4_arbiter
  import inc_4_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_REQ-1:0]      i_Req,
  input  logic [OP_W*NUM_REQ-1:0] i_Operand,
  output logic [NUM_REQ-1:0]      o_Grant,
  output logic [NUM_REQ-1:0]      o_Valid,
  output logic [OP_W-1:0]         o_Result,
  output logic                    o_Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] win_idx;
  logic [OP_W-1:0]  op_reg;
  logic [OP_W-1:0]  inc_out;
  logic [OP_W-1:0]  ops [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = i_Operand[g*OP_W +: OP_W];
  end

  // Walk from farthest to nearest so the first requester after last wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign win_idx = rr_pick(i_Req, last_idx);

  inc_4 u_inc_4 (
    .i_Clk     (i_Clk),
    .i_Operand (op_reg),
    .o_Result  (inc_out)
  );

  // Busy also covers the cycle in which the result is presented.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= ST_IDLE;
      o_Grant  <= '0;
      o_Valid  <= '0;
      o_Result <= '0;
      o_Busy   <= 1'b0;
      op_reg   <= '0;
      cur_idx  <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      o_Grant  <= '0;
      o_Valid  <= '0;
      o_Result <= '0;
      case (state)
        ST_IDLE: begin
          o_Busy <= |i_Req;
          if (|i_Req) begin
            cur_idx  <= win_idx;
            last_idx <= win_idx;
            op_reg   <= ops[win_idx];
            o_Grant  <= ONE << win_idx;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_Busy <= 1'b1;
          state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          o_Busy   <= 1'b1;
          o_Result <= inc_out;
          o_Valid  <= ONE << cur_idx;
          state    <= ST_IDLE;
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inc_4_arbiter.sv
// Directed bench for inc_4_arbiter with hand-computed expectations.
module tb_inc_4_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] operand;
  logic [3:0]  grant;
  logic [3:0]  valid;
  logic [3:0]  result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  inc_4_arbiter #(.NUM_REQ(4)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Req     (req),
    .i_Operand (operand),
    .o_Grant   (grant),
    .o_Valid   (valid),
    .o_Result  (result),
    .o_Busy    (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulsed request; operand is switched to op_late right after the grant.
  task automatic run_one(input int idx, input logic [3:0] op, input logic [3:0] op_late,
                         input logic [3:0] exp, input string tag);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    req = oh;
    operand = '0;
    operand[idx*4 +: 4] = op;
    tick();
    chk({tag, ".grant"}, grant, oh);
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".valid0"}, valid, 0);
    req = '0;
    operand[idx*4 +: 4] = op_late;
    tick();
    chk({tag, ".grant_off"}, grant, 0);
    chk({tag, ".busy1"}, busy, 1);
    chk({tag, ".valid1"}, valid, 0);
    tick();
    chk({tag, ".valid"}, valid, oh);
    chk({tag, ".result"}, result, exp);
    chk({tag, ".busy2"}, busy, 1);
    chk({tag, ".grant2"}, grant, 0);
    tick();
    chk({tag, ".busy_end"}, busy, 0);
    chk({tag, ".valid_end"}, valid, 0);
  endtask

  initial begin
    int          order [5];
    logic [3:0]  res   [5];
    order = '{0, 1, 2, 3, 0};
    res   = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h2};

    rst_n = 1'b0;
    req = '0;
    operand = '0;
    #5;
    chk("rst.grant", grant, 0);
    chk("rst.valid", valid, 0);
    chk("rst.result", result, 0);
    chk("rst.busy", busy, 0);
    #45 rst_n = 1'b1;
    tick();
    chk("idle.busy", busy, 0);
    chk("idle.grant", grant, 0);

    run_one(0, 4'h5, 4'h5, 4'h6, "single");
    run_one(3, 4'hF, 4'hF, 4'h0, "wrap");

    // All four held: grants rotate 0,1,2,3,0 every third edge.
    req = 4'b1111;
    operand = 16'h4321;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("all%0d.grant", n), grant, 32'(1 << order[n]));
      chk($sformatf("all%0d.valid0", n), valid, 0);
      if (n == 4) req = '0;
      tick();
      chk($sformatf("all%0d.grant_off", n), grant, 0);
      tick();
      chk($sformatf("all%0d.valid", n), valid, 32'(1 << order[n]));
      chk($sformatf("all%0d.result", n), result, res[n]);
      chk($sformatf("all%0d.nogrant", n), grant, 0);
    end
    tick();
    chk("all.busy_end", busy, 0);

    // Rotation: after 1 wins, 0 and 1 together -> 0 then 1.
    run_one(1, 4'h1, 4'h1, 4'h2, "rot_pre");
    req = 4'b0011;
    operand = 16'h00C6;
    tick();
    chk("rot.grant0", grant, 4'b0001);
    tick();
    tick();
    chk("rot.valid0", valid, 4'b0001);
    chk("rot.result0", result, 4'h7);
    tick();
    chk("rot.grant1", grant, 4'b0010);
    req = '0;
    tick();
    tick();
    chk("rot.valid1", valid, 4'b0010);
    chk("rot.result1", result, 4'hD);
    tick();

    run_one(2, 4'h7, 4'hA, 4'h8, "late_op");

    // Reset while in ISSUE drops the operation.
    req = 4'b0001;
    operand = 16'h0003;
    tick();
    chk("mid.grant", grant, 4'b0001);
    req = '0;
    #5 rst_n = 1'b0;
    #1;
    chk("mid.grant_rst", grant, 0);
    chk("mid.busy_rst", busy, 0);
    chk("mid.valid_rst", valid, 0);
    chk("mid.result_rst", result, 0);
    tick();
    #10 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("mid.novalid%0d", n), valid, 0);
      chk($sformatf("mid.idle_busy%0d", n), busy, 0);
    end

    run_one(0, 4'h9, 4'h9, 4'hA, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
